// File: rtl/core_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
//   fetch_entry_t     : one buffered fetch result {addr, instr}
//   INSTR_WORD_BYTES  : address stride between sequential fetches
//   DEFAULT_BOOT_ADDR : default first fetch address after reset
//   word_align()      : clears the byte-offset bits of an address
package core_prefetch_pkg;

    localparam int unsigned INSTR_WORD_BYTES  = 4;
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h3000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/core_instr_prefetch_if.sv
// Core instruction bus: request/grant address phase, in-order rvalid/rdata
// response phase.
//   master : the fetch initiator (drives req/addr, receives gnt/rvalid/rdata)
//   slave  : the instruction memory side
interface core_instr_prefetch_if;

    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_gnt_i,
        input  instr_rvalid_i,
        input  instr_rdata_i
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_gnt_i,
        output instr_rvalid_i,
        output instr_rdata_i
    );

endinterface

// File: rtl/prefetch_fifo.sv
// Show-ahead synchronous FIFO of fetch_entry_t used as the fetched
// instruction buffer. The head entry is visible on 'head' whenever the FIFO
// is not empty. Flush has priority over push and pop.
//   clk, srst        : clock, synchronous active-high reset
//   push, push_data  : write one entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   flush            : discard all entries
//   head             : current head entry
//   count/empty/full : occupancy
module prefetch_fifo
    import core_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full
);

    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (32'(count_reg) == DEPTH);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The decode port needs the head word in the same cycle it becomes
    // valid, so the head is read straight out of the (small) array.
    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !srst) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/core_instr_prefetch.sv
// Instruction prefetcher: issues sequential word fetches on the core
// instruction bus starting at BOOT_ADDR (or a branch target), buffers the
// responses and presents them to decode over a valid/ready port.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   bus (master)        : instr_req/addr/gnt/rvalid/rdata
//   branch_i/addr_i     : one-cycle redirect of the fetch stream
//   fetch_valid_o/ready : decode handshake; fetch_instr_o/fetch_addr_o data
//   busy_o              : requests in flight or responses still to discard
// Optional build macro CORE_PREFETCH_BYPASS_EN: a response arriving into an
// empty buffer is shown on the fetch port in the same cycle.
module core_instr_prefetch
    import core_prefetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BOOT_ADDR       = DEFAULT_BOOT_ADDR
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    core_instr_prefetch_if.master bus,
    input  logic                  branch_i,
    input  logic [31:0]           branch_addr_i,
    output logic                  fetch_valid_o,
    input  logic                  fetch_ready_i,
    output logic [31:0]           fetch_instr_o,
    output logic [31:0]           fetch_addr_o,
    output logic                  busy_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [OW-1:0] OUT_ONE  = OW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PEND_ONE = PW'(1);

    logic          req_reg, req_next;
    logic [31:0]   addr_reg, addr_next;
    logic          redirect_reg, redirect_next;        // held request belongs to the old stream
    logic [31:0]   redirect_addr_reg, redirect_addr_next;
    logic [OW-1:0] outstanding_reg, outstanding_next;
    logic [OW-1:0] discard_reg, discard_next;

    // In-order addresses of granted requests awaiting rvalid.
    logic [31:0]   pend_addr [MAX_OUTSTANDING];
    logic [PW-1:0] pend_wr_reg, pend_rd_reg;

    logic          gnt_acc, rv_acc, bypass_valid;
    logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count, fifo_count_next;
    fetch_entry_t  fifo_head, push_entry;

    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PEND_ONE;
    endfunction

    assign gnt_acc = req_reg && bus.instr_gnt_i;
    // A stray rvalid with nothing in flight is ignored.
    assign rv_acc  = bus.instr_rvalid_i && (outstanding_reg != '0);

`ifdef CORE_PREFETCH_BYPASS_EN
    assign bypass_valid = fifo_empty && !branch_i && (discard_reg == '0) && rv_acc;
`else
    assign bypass_valid = 1'b0;
`endif

    always_comb begin
        push_entry       = '{addr: pend_addr[pend_rd_reg], instr: bus.instr_rdata_i};
        fifo_pop         = fetch_ready_i && !fifo_empty && !branch_i;
        // A bypassed word taken by decode this cycle never enters the buffer;
        // anything arriving during a branch belongs to the old stream.
        fifo_push        = rv_acc && (discard_reg == '0) && !branch_i
                           && !(bypass_valid && fetch_ready_i);
        fifo_count_next  = fifo_count;
        if (branch_i) begin
            fifo_count_next = '0;
        end else begin
            if (fifo_push && !fifo_full) fifo_count_next = fifo_count_next + CNT_ONE;
            if (fifo_pop)                fifo_count_next = fifo_count_next - CNT_ONE;
        end

        outstanding_next = outstanding_reg;
        if (gnt_acc && !rv_acc) outstanding_next = outstanding_reg + OUT_ONE;
        if (rv_acc && !gnt_acc) outstanding_next = outstanding_reg - OUT_ONE;

        if (branch_i) begin
            // Everything still in flight after this cycle is old-stream.
            discard_next = outstanding_next;
        end else begin
            discard_next = discard_reg;
            if (rv_acc && discard_reg != '0) discard_next = discard_next - OUT_ONE;
            if (gnt_acc && redirect_reg)     discard_next = discard_next + OUT_ONE;
        end

        addr_next          = addr_reg;
        redirect_next      = redirect_reg;
        redirect_addr_next = redirect_addr_reg;
        if (gnt_acc) begin
            addr_next     = redirect_reg ? redirect_addr_reg : addr_reg + 32'(INSTR_WORD_BYTES);
            redirect_next = 1'b0;
        end
        if (branch_i) begin
            if (req_reg && !bus.instr_gnt_i) begin
                // The bus request must stay stable; park the target until granted.
                redirect_next      = 1'b1;
                redirect_addr_next = word_align(branch_addr_i);
            end else begin
                addr_next     = word_align(branch_addr_i);
                redirect_next = 1'b0;
            end
        end

        // Every request reserves a buffer slot, so a response is never refused.
        req_next = (req_reg && !bus.instr_gnt_i)
                   || ((32'(outstanding_next) < MAX_OUTSTANDING)
                       && ((32'(fifo_count_next) + 32'(outstanding_next)) < FIFO_DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req_reg           <= 1'b0;
            addr_reg          <= BOOT_ADDR;
            redirect_reg      <= 1'b0;
            redirect_addr_reg <= '0;
            outstanding_reg   <= '0;
            discard_reg       <= '0;
            pend_wr_reg       <= '0;
            pend_rd_reg       <= '0;
        end else begin
            req_reg           <= req_next;
            addr_reg          <= addr_next;
            redirect_reg      <= redirect_next;
            redirect_addr_reg <= redirect_addr_next;
            outstanding_reg   <= outstanding_next;
            discard_reg       <= discard_next;
            if (gnt_acc) pend_wr_reg <= pend_inc(pend_wr_reg);
            if (rv_acc)  pend_rd_reg <= pend_inc(pend_rd_reg);
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_acc && !reset_i) begin
            pend_addr[pend_wr_reg] <= addr_reg;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && bus.instr_rvalid_i) begin
            assert (outstanding_reg != '0) else $error("instr_rvalid_i with no request in flight");
        end
    end
`endif

    prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_i),
        .srst      (reset_i),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (branch_i),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.instr_req_o  = req_reg;
    assign bus.instr_addr_o = addr_reg;
    assign busy_o           = (outstanding_reg != '0) || (discard_reg != '0);
    assign fetch_valid_o    = !fifo_empty || bypass_valid;
    assign fetch_instr_o    = !fifo_empty ? fifo_head.instr
                            : (bypass_valid ? bus.instr_rdata_i : 32'h0);
    assign fetch_addr_o     = !fifo_empty ? fifo_head.addr
                            : (bypass_valid ? pend_addr[pend_rd_reg] : 32'h0);

endmodule

// File: tb/tb_core_instr_prefetch.sv
module tb_core_instr_prefetch;
    import core_prefetch_pkg::*;

    localparam logic [31:0] BOOT    = 32'h3000_0000;
    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;
`ifdef CORE_PREFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_addr_o;
    logic        busy_o;

    logic        gnt_en;
    int          rv_lat;
    logic        force_en;
    logic [31:0] force_data;

    logic [31:0] pq_addr[$];
    int          pq_t[$];
    logic [31:0] grant_log[$];
    logic [31:0] del_addr[$];
    logic [31:0] del_instr[$];
    int          cyc, n_grant, n_rv;
    int          n_cmp, n_bad;

    core_instr_prefetch_if bus();
    assign bus.instr_gnt_i = bus.instr_req_o && gnt_en;

    core_instr_prefetch #(
        .FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .BOOT_ADDR(BOOT)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .bus           (bus),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_ready_i (fetch_ready_i),
        .fetch_instr_o (fetch_instr_o),
        .fetch_addr_o  (fetch_addr_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // Memory slave: grants via gnt_en, answers in order rv_lat cycles after grant.
    initial begin
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = '0;
        cyc = 0; n_grant = 0; n_rv = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (bus.instr_rvalid_i) n_rv++;
            if (bus.instr_req_o && bus.instr_gnt_i) begin
                pq_addr.push_back(bus.instr_addr_o);
                pq_t.push_back(cyc);
                grant_log.push_back(bus.instr_addr_o);
                n_grant++;
                $display("[%0t] grant addr=%h", $time, bus.instr_addr_o);
            end
            if (fetch_valid_o && fetch_ready_i) begin
                del_addr.push_back(fetch_addr_o);
                del_instr.push_back(fetch_instr_o);
                $display("[%0t] deliver addr=%h instr=%h", $time, fetch_addr_o, fetch_instr_o);
            end
            #1;
            bus.instr_rvalid_i = 1'b0;
            if (pq_addr.size() > 0 && (cyc - pq_t[0]) >= rv_lat - 1) begin
                bus.instr_rvalid_i = 1'b1;
                bus.instr_rdata_i  = force_en ? force_data : (pq_addr[0] ^ XOR_KEY);
                void'(pq_addr.pop_front());
                void'(pq_t.pop_front());
            end
        end
    end

    task automatic clear_logs();
        pq_addr.delete(); pq_t.delete(); grant_log.delete();
        del_addr.delete(); del_instr.delete();
        n_grant = 0; n_rv = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        gnt_en = 1'b0; reset_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0;
        fetch_ready_i = 1'b0; force_en = 1'b0; rv_lat = 1;
        bus.instr_rvalid_i = 1'b0;
        clear_logs();
        repeat (3) @(negedge clk);
        clear_logs();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        gnt_en = 1'b0; reset_i = 1'b1; branch_i = 1'b0; fetch_ready_i = 1'b0;
        bus.instr_rvalid_i = 1'b0;
        clear_logs();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b want=0", bus.instr_req_o); end
        n_cmp++; if (bus.instr_addr_o !== BOOT) begin n_bad++; $display("FAIL reset_addr got=%h want=%h", bus.instr_addr_o, BOOT); end
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", fetch_valid_o); end
        n_cmp++; if (fetch_instr_o !== 32'h0) begin n_bad++; $display("FAIL reset_instr got=%h want=0", fetch_instr_o); end
        n_cmp++; if (fetch_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_faddr got=%h want=0", fetch_addr_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a [3];
        logic [31:0] exp_i [3];
        exp_a = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008};
        exp_i = '{32'h95A5_0000, 32'h95A5_0004, 32'h95A5_0008};
        do_reset();
        gnt_en = 1'b1; rv_lat = 1; fetch_ready_i = 1'b1;
        for (int i = 0; i < 60 && del_addr.size() < 3; i++) @(negedge clk);
        n_cmp++;
        if (del_addr.size() < 3) begin
            n_bad++; $display("FAIL seq_timeout delivered=%0d want>=3", del_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (grant_log[k] !== exp_a[k]) begin n_bad++; $display("FAIL seq_grant%0d got=%h want=%h", k, grant_log[k], exp_a[k]); end
                n_cmp++; if (del_addr[k] !== exp_a[k]) begin n_bad++; $display("FAIL seq_addr%0d got=%h want=%h", k, del_addr[k], exp_a[k]); end
                n_cmp++; if (del_instr[k] !== exp_i[k]) begin n_bad++; $display("FAIL seq_instr%0d got=%h want=%h", k, del_instr[k], exp_i[k]); end
            end
        end
    endtask

    task automatic test_no_ready();
        bit unstable;
        do_reset();
        gnt_en = 1'b1; rv_lat = 1; fetch_ready_i = 1'b0;
        for (int i = 0; i < 20 && fetch_valid_o !== 1'b1; i++) @(negedge clk);
        unstable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h3000_0000 || fetch_instr_o !== 32'h95A5_0000)
                unstable = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (unstable !== 1'b0) begin n_bad++; $display("FAIL stall_stable got=unstable want=stable head %h/%h", fetch_addr_o, fetch_instr_o); end
        n_cmp++; if (n_grant !== 4) begin n_bad++; $display("FAIL stall_grants got=%0d want=4", n_grant); end
        n_cmp++; if (bus.instr_req_o !== 1'b0) begin n_bad++; $display("FAIL stall_req got=%b want=0", bus.instr_req_o); end
        fetch_ready_i = 1'b1;
        @(negedge clk);
        fetch_ready_i = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (n_grant !== 5) begin n_bad++; $display("FAIL pulse_grants got=%0d want=5", n_grant); end
        n_cmp++;
        if (grant_log.size() < 5) begin n_bad++; $display("FAIL pulse_new_addr got=none want=30000010"); end
        else if (grant_log[4] !== 32'h3000_0010) begin n_bad++; $display("FAIL pulse_new_addr got=%h want=30000010", grant_log[4]); end
        n_cmp++; if (fetch_addr_o !== 32'h3000_0004) begin n_bad++; $display("FAIL pulse_head_addr got=%h want=30000004", fetch_addr_o); end
        n_cmp++; if (fetch_instr_o !== 32'h95A5_0004) begin n_bad++; $display("FAIL pulse_head_instr got=%h want=95a50004", fetch_instr_o); end
        n_cmp++; if (bus.instr_req_o !== 1'b0) begin n_bad++; $display("FAIL pulse_req got=%b want=0", bus.instr_req_o); end
    endtask

    task automatic test_branch_discard();
        do_reset();
        gnt_en = 1'b1; rv_lat = 4; fetch_ready_i = 1'b1;
        for (int i = 0; i < 20 && n_grant < 2; i++) @(negedge clk);
        n_cmp++; if (n_grant !== 2) begin n_bad++; $display("FAIL br_outstanding got=%0d want=2", n_grant); end
        branch_i = 1'b1; branch_addr_i = 32'h3000_0102;
        @(negedge clk);
        branch_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL br_busy got=%b want=1", busy_o); end
        for (int i = 0; i < 40 && del_addr.size() < 1; i++) @(negedge clk);
        n_cmp++;
        if (del_addr.size() < 1 || grant_log.size() < 3) begin
            n_bad++; $display("FAIL br_timeout delivered=%0d grants=%0d", del_addr.size(), grant_log.size());
        end else begin
            n_cmp++; if (grant_log[2] !== 32'h3000_0100) begin n_bad++; $display("FAIL br_req_addr got=%h want=30000100", grant_log[2]); end
            n_cmp++; if (del_addr[0] !== 32'h3000_0100) begin n_bad++; $display("FAIL br_first_addr got=%h want=30000100", del_addr[0]); end
            n_cmp++; if (del_instr[0] !== 32'h95A5_0100) begin n_bad++; $display("FAIL br_first_instr got=%h want=95a50100", del_instr[0]); end
        end
    endtask

    task automatic test_gnt_withheld();
        do_reset();
        gnt_en = 1'b0; rv_lat = 1; fetch_ready_i = 1'b1;
        for (int i = 0; i < 10 && bus.instr_req_o !== 1'b1; i++) @(negedge clk);
        branch_i = 1'b1; branch_addr_i = 32'h3000_0201;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (bus.instr_req_o !== 1'b1) begin n_bad++; $display("FAIL hold_req%0d got=%b want=1", c, bus.instr_req_o); end
            n_cmp++; if (bus.instr_addr_o !== BOOT) begin n_bad++; $display("FAIL hold_addr%0d got=%h want=%h", c, bus.instr_addr_o, BOOT); end
            @(negedge clk);
            branch_i = 1'b0;
        end
        gnt_en = 1'b1;
        for (int i = 0; i < 30 && del_addr.size() < 1; i++) @(negedge clk);
        n_cmp++;
        if (del_addr.size() < 1 || grant_log.size() < 2) begin
            n_bad++; $display("FAIL hold_timeout delivered=%0d grants=%0d", del_addr.size(), grant_log.size());
        end else begin
            n_cmp++; if (grant_log[0] !== BOOT) begin n_bad++; $display("FAIL hold_grant0 got=%h want=%h", grant_log[0], BOOT); end
            n_cmp++; if (grant_log[1] !== 32'h3000_0200) begin n_bad++; $display("FAIL hold_grant1 got=%h want=30000200", grant_log[1]); end
            n_cmp++; if (del_addr[0] !== 32'h3000_0200) begin n_bad++; $display("FAIL hold_first_addr got=%h want=30000200", del_addr[0]); end
            n_cmp++; if (del_instr[0] !== 32'h95A5_0200) begin n_bad++; $display("FAIL hold_first_instr got=%h want=95a50200", del_instr[0]); end
        end
    endtask

    task automatic test_slow_rvalid();
        int max_unans, busy_bad;
        do_reset();
        gnt_en = 1'b1; rv_lat = 5; fetch_ready_i = 1'b1;
        max_unans = 0; busy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (n_grant - n_rv > max_unans) max_unans = n_grant - n_rv;
            if (n_grant > 0 && busy_o !== 1'b1) busy_bad++;
        end
        n_cmp++; if (max_unans !== 2) begin n_bad++; $display("FAIL slow_max_outstanding got=%0d want=2", max_unans); end
        n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL slow_busy low_cycles=%0d want=0", busy_bad); end
        n_cmp++; if (n_rv < 4) begin n_bad++; $display("FAIL slow_progress responses=%0d want>=4", n_rv); end
    endtask

    task automatic test_bypass();
        do_reset();
        gnt_en = 1'b1; rv_lat = 3; fetch_ready_i = 1'b0;
        force_en = 1'b1; force_data = 32'hDEAD_DEAD;
        for (int i = 0; i < 10 && n_grant < 1; i++) @(negedge clk);
        gnt_en = 1'b0;
        for (int i = 0; i < 10 && bus.instr_rvalid_i !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (bus.instr_rvalid_i !== 1'b1) begin n_bad++; $display("FAIL byp_rvalid_timeout got=0 want=1"); end
        n_cmp++; if (fetch_valid_o !== BYP) begin n_bad++; $display("FAIL byp_same_valid got=%b want=%b", fetch_valid_o, BYP); end
        n_cmp++; if (fetch_instr_o !== (BYP ? 32'hDEAD_DEAD : 32'h0)) begin n_bad++; $display("FAIL byp_same_instr got=%h", fetch_instr_o); end
        @(negedge clk);
        n_cmp++; if (fetch_valid_o !== 1'b1) begin n_bad++; $display("FAIL byp_next_valid got=%b want=1", fetch_valid_o); end
        n_cmp++; if (fetch_instr_o !== 32'hDEAD_DEAD) begin n_bad++; $display("FAIL byp_next_instr got=%h want=deaddead", fetch_instr_o); end
        n_cmp++; if (fetch_addr_o !== BOOT) begin n_bad++; $display("FAIL byp_next_addr got=%h want=%h", fetch_addr_o, BOOT); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0; fetch_ready_i = 1'b0;
        gnt_en = 1'b0; rv_lat = 1; force_en = 1'b0; force_data = '0;
        test_reset();
        test_sequential();
        test_no_ready();
        test_branch_discard();
        test_gnt_withheld();
        test_slow_rvalid();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
